// File: rtl/i2s_stereo_rx_pkg.sv
// ---------------------------------------------------------------------------
// i2s_stereo_rx_pkg : shared FSM state type and default frame constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package i2s_stereo_rx_pkg;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   localparam int I2S_DATA_WIDTH  = 16;
   localparam int I2S_SLOT_WIDTH  = 32;
   localparam int I2S_FILL_FRAMES = 90;

endpackage

`default_nettype wire

// File: rtl/i2s_sync_edge.sv
// ---------------------------------------------------------------------------
// i2s_sync_edge : two-flop synchroniser for a strobe plus data bits, with a
//                 rising-edge detect on the strobe only.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2s_sync_edge #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             edge_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             rise_o,
   output logic [WIDTH-1:0] data_o
);

   logic             edge_meta_q, edge_sync_q, edge_prev_q;
   logic [WIDTH-1:0] data_meta_q, data_sync_q;

   // Strobe and data share the same flop depth so they stay aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         edge_meta_q <= 1'b0;
         edge_sync_q <= 1'b0;
         edge_prev_q <= 1'b0;
         data_meta_q <= '0;
         data_sync_q <= '0;
      end else begin
         edge_meta_q <= edge_i;
         edge_sync_q <= edge_meta_q;
         edge_prev_q <= edge_sync_q;
         data_meta_q <= data_i;
         data_sync_q <= data_meta_q;
      end
   end

   assign rise_o = edge_sync_q & ~edge_prev_q;
   assign data_o = data_sync_q;

endmodule

`default_nettype wire

// File: rtl/i2s_stereo_rx.sv
// ---------------------------------------------------------------------------
// i2s_stereo_rx : I2S stereo receiver with frame fill counter and sticky
//                 trigger; define ONSET_TRIGGER_EN for magnitude gating.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module i2s_stereo_rx
   import i2s_stereo_rx_pkg::*;
#(
   parameter int                    DATA_WIDTH  = I2S_DATA_WIDTH,
   parameter int                    SLOT_WIDTH  = I2S_SLOT_WIDTH,
   parameter int                    FILL_FRAMES = I2S_FILL_FRAMES,
   parameter logic [DATA_WIDTH-1:0] THRESHOLD   = 'h0800
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i2s_sck,
   input  logic                  i2s_ws,
   input  logic                  i2s_sd,
   output logic [DATA_WIDTH-1:0] left_data,
   output logic [DATA_WIDTH-1:0] right_data,
   output logic                  sample_valid,
   output logic                  trigger,
   output logic                  frame_err
);

   localparam int CW = $clog2(SLOT_WIDTH + 1);
   localparam int FW = $clog2(FILL_FRAMES + 1);
   localparam logic [CW-1:0] SLOT_MAX = CW'(SLOT_WIDTH);
   localparam logic [CW-1:0] DW_CNT   = CW'(DATA_WIDTH);
   localparam logic [FW-1:0] FILL_MAX = FW'(FILL_FRAMES);

   logic       sck_rise;
   logic [1:0] sync_data;
   logic       ws_s, sd_s;

   i2s_sync_edge #(.WIDTH(2)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .edge_i (i2s_sck),
      .data_i ({i2s_sd, i2s_ws}),
      .rise_o (sck_rise),
      .data_o (sync_data)
   );

   assign ws_s = sync_data[0];
   assign sd_s = sync_data[1];

   state_t                state_q, state_d;
   logic                  ws_prev_q, ws_prev_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] pending_q, pending_d;
   logic                  pend_ok_q, pend_ok_d;
   logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
   logic                  valid_q, valid_d, err_q, err_d, trig_q, trig_d;
   logic [FW-1:0]         frame_cnt_q, frame_cnt_d;

   logic [CW-1:0]         cnt_inc;
   logic [DATA_WIDTH-1:0] shift_upd;
   logic                  slot_ok, boundary, onset;

   // The bit seen on the boundary rise is still the LSB of the slot that ends.
   assign cnt_inc   = (bit_cnt_q == SLOT_MAX) ? bit_cnt_q : bit_cnt_q + 1'b1;
   assign shift_upd = (bit_cnt_q < DW_CNT) ? {shift_q[DATA_WIDTH-2:0], sd_s} : shift_q;
   assign slot_ok   = (cnt_inc >= DW_CNT);
   assign boundary  = (ws_s != ws_prev_q);

`ifdef ONSET_TRIGGER_EN
   function automatic logic [DATA_WIDTH-1:0] mag_sat(input logic [DATA_WIDTH-1:0] v);
      if (!v[DATA_WIDTH-1])
         return v;
      if (v[DATA_WIDTH-2:0] == '0)
         return {1'b0, {(DATA_WIDTH-1){1'b1}}};
      return -v;
   endfunction

   assign onset = (mag_sat(left_q) >= THRESHOLD) || (mag_sat(right_q) >= THRESHOLD);
`else
   logic unused_threshold;
   assign unused_threshold = ^THRESHOLD;
   assign onset            = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      ws_prev_d   = ws_prev_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      pending_d   = pending_q;
      pend_ok_d   = pend_ok_q;
      left_d      = left_q;
      right_d     = right_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      frame_cnt_d = (valid_q && frame_cnt_q != FILL_MAX) ? frame_cnt_q + 1'b1 : frame_cnt_q;
      trig_d      = trig_q | (valid_q && frame_cnt_d == FILL_MAX && onset);

      if (sck_rise) begin
         ws_prev_d = ws_s;
         case (state_q)
            SYNC: begin
               if (boundary && !ws_s) begin
                  state_d   = LEFT;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end
            end
            LEFT: begin
               if (boundary) begin
                  state_d   = RIGHT;
                  pending_d = shift_upd;
                  pend_ok_d = slot_ok;
                  err_d     = !slot_ok;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end else begin
                  bit_cnt_d = cnt_inc;
                  shift_d   = shift_upd;
               end
            end
            RIGHT: begin
               if (boundary) begin
                  state_d   = LEFT;
                  bit_cnt_d = '0;
                  shift_d   = '0;
                  if (pend_ok_q && slot_ok) begin
                     left_d  = pending_q;
                     right_d = shift_upd;
                     valid_d = 1'b1;
                  end else begin
                     err_d = !slot_ok;
                  end
               end else begin
                  bit_cnt_d = cnt_inc;
                  shift_d   = shift_upd;
               end
            end
            default: state_d = SYNC;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SYNC;
         ws_prev_q   <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         pending_q   <= '0;
         pend_ok_q   <= 1'b0;
         left_q      <= '0;
         right_q     <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         trig_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ws_prev_q   <= ws_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         pending_q   <= pending_d;
         pend_ok_q   <= pend_ok_d;
         left_q      <= left_d;
         right_q     <= right_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         trig_q      <= trig_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign left_data    = left_q;
   assign right_data   = right_q;
   assign sample_valid = valid_q;
   assign frame_err    = err_q;
   assign trigger      = trig_q;

endmodule

`default_nettype wire
